// File: rtl/out_burst_ctrl.sv
// out_burst_ctrl: plans 4KB-safe AXI4 write bursts for one output page
// and gates the upstream 64B beat stream onto the W channel.
module out_burst_ctrl #(
  parameter int ADDR_W          = 64,
  parameter int MAX_BEATS       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [31:0]       decompression_length,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              src_valid,
  input  logic              src_last,
  input  logic [511:0]      src_data,
  output logic              src_ready,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              wvalid,
  input  logic              wready,
  output logic [511:0]      wdata,
  output logic [63:0]       wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [ADDR_W-1:0] r_w_addr;
  logic [26:0]       r_aw_rem;
  logic [26:0]       r_w_rem;
  logic [6:0]        r_w_cnt;
  logic [OW-1:0]     r_outst;
  logic [OW-1:0]     r_credit;
  logic [5:0]        r_len_lo;
  logic              r_error;

  logic [26:0]       w_total;
  logic [6:0]        w_aw_size;
  logic [6:0]        w_w_size;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_w_allowed;
  logic              w_w_end;
  logic              w_page_end;

  // min(remaining, MAX_BEATS, beats left before the next 4KB boundary)
  function automatic logic [6:0] f_burst(
    input logic [ADDR_W-1:0] a,
    input logic [26:0]       rem
  );
    logic [6:0] b4k;
    logic [6:0] s;
    b4k = 7'd64 - {1'b0, a[11:6]};
    s   = (b4k < 7'(MAX_BEATS)) ? b4k : 7'(MAX_BEATS);
    if (rem < {20'd0, s}) s = rem[6:0];
    return s;
  endfunction

  assign w_total = {1'b0, decompression_length[31:6]}
                 + {26'd0, |decompression_length[5:0]};

  assign w_aw_size = f_burst(r_aw_addr, r_aw_rem);
  assign w_w_size  = f_burst(r_w_addr, r_w_rem);

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign bready = busy;
  assign error  = r_error;

  assign awvalid = (r_state == S_RUN) && (r_aw_rem != '0)
                && (r_outst < OW'(MAX_OUTSTANDING));
  assign awaddr  = r_aw_addr;
  assign awlen   = {1'b0, w_aw_size} - 8'd1;

  assign w_w_allowed = (r_credit != '0);
  assign wvalid      = src_valid & w_w_allowed;
  assign src_ready   = wready & w_w_allowed;
  assign wdata       = src_data;
  assign w_w_end     = (r_w_cnt == w_w_size - 7'd1);
  assign wlast       = w_w_allowed & w_w_end;
  assign w_page_end  = w_w_end && ({20'd0, w_w_size} == r_w_rem);
  assign wstrb = (w_page_end && r_len_lo != 6'd0)
               ? ~({64{1'b1}} << r_len_lo) : {64{1'b1}};

  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_b_hs  = bvalid & bready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (decompression_length == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_aw_rem == '0 && r_w_rem == '0) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_outst == '0) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_aw_addr <= '0;
      r_w_addr  <= '0;
      r_aw_rem  <= '0;
      r_w_rem   <= '0;
      r_w_cnt   <= '0;
      r_outst   <= '0;
      r_credit  <= '0;
      r_len_lo  <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_aw_addr <= dest_addr;
          r_w_addr  <= dest_addr;
          r_aw_rem  <= w_total;
          r_w_rem   <= w_total;
          r_w_cnt   <= '0;
          r_outst   <= '0;
          r_credit  <= '0;
          r_len_lo  <= decompression_length[5:0];
          r_error   <= 1'b0;
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_addr <= r_aw_addr + (ADDR_W'(w_aw_size) << 6);
          r_aw_rem  <= r_aw_rem - 27'(w_aw_size);
        end
        if (w_w_hs) begin
          if (w_w_end) begin
            r_w_cnt  <= '0;
            r_w_addr <= r_w_addr + (ADDR_W'(w_w_size) << 6);
            r_w_rem  <= r_w_rem - 27'(w_w_size);
          end else begin
            r_w_cnt <= r_w_cnt + 7'd1;
          end
        end
        r_outst  <= r_outst + OW'(w_aw_hs) - OW'(w_b_hs);
        // W may only run on bursts whose AW has already been accepted
        r_credit <= r_credit + OW'(w_aw_hs) - OW'(w_w_hs & w_w_end);
        if ((w_b_hs && bresp != 2'b00) ||
            (w_w_hs && src_last != w_w_end)) begin
          r_error <= 1'b1;
        end
      end
    end
  end

endmodule
